// File: rtl/pitch_period_estimator_if.sv
// Sample-in / pitch-out bundle for the pitch period estimator.
// The master side is the audio source and consumer; the slave side is the estimator.
interface pitch_period_estimator_if #(
  parameter int DATA_W = 16
);
  logic                     enable;
  logic                     sample_valid;
  logic signed [DATA_W-1:0] sample;
  logic [14:0]              freq_hz;
  logic                     freq_valid;
  logic                     no_pitch;
  logic                     busy;

  modport master (
    output enable, sample_valid, sample,
    input  freq_hz, freq_valid, no_pitch, busy
  );

  modport slave (
    input  enable, sample_valid, sample,
    output freq_hz, freq_valid, no_pitch, busy
  );
endinterface

// File: rtl/pitch_period_estimator.sv
// Pitch period estimator: finds rising zero crossings with hysteresis and sums
// PERIODS consecutive periods. It converts the sum to Hz with a bit-serial
// restoring divide of PERIODS*SAMPLE_RATE by that sum.
module pitch_period_estimator #(
  parameter int SAMPLE_RATE = 48000,
  parameter int PERIODS     = 4,
  parameter int HYST        = 256,
  parameter int MIN_PERIOD  = 6,
  parameter int MAX_PERIOD  = 3000,
  parameter int DATA_W      = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  pitch_period_estimator_if.slave bus
);

  localparam int CNT_W  = 12;
  localparam int ACC_W  = 15;
  localparam int IDX_W  = 4;
  localparam int NUM_W  = 18;
  localparam int FREQ_W = 15;
  localparam int IT_W   = 5;

  localparam logic [NUM_W-1:0]         NUMER    = NUM_W'(PERIODS * SAMPLE_RATE);
  localparam logic [CNT_W-1:0]         MIN_CNT  = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]         MAX_CNT  = CNT_W'(MAX_PERIOD);
  localparam logic [IDX_W-1:0]         IDX_LAST = IDX_W'(PERIODS - 1);
  localparam logic [IT_W-1:0]          IT_LAST  = IT_W'(NUM_W - 1);
  localparam logic signed [DATA_W-1:0] HYST_POS = DATA_W'(HYST);
  localparam logic signed [DATA_W-1:0] HYST_NEG = -HYST_POS;

  typedef enum logic       {T_SEEK, T_TRACK} trk_state_t;
  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_OUT} div_state_t;

  // Quotient truncated by the divide itself, clipped to the 15-bit output range.
  function automatic logic [FREQ_W-1:0] sat_quotient(input logic [NUM_W-1:0] q);
    if (q > NUM_W'(32767)) return '1;
    return q[FREQ_W-1:0];
  endfunction

  // Tracker state
  trk_state_t       trk_q, trk_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             no_pitch_q, no_pitch_d;
  logic             ld_q, ld_d;
  logic [ACC_W-1:0] ld_sum_q, ld_sum_d;

  // Divider state
  div_state_t        div_q, div_d;
  logic [IT_W-1:0]   it_q, it_d;
  logic [FREQ_W-1:0] freq_hz_q, freq_hz_d;
  logic [ACC_W-1:0]  rem_q, rem_d;
  logic [NUM_W-1:0]  quo_q, quo_d;
  logic [ACC_W-1:0]  dvs_q, dvs_d;

  logic             is_low, crossing;
  logic [CNT_W-1:0] per_len;
  logic [ACC_W-1:0] sum_next;
  logic [ACC_W:0]   shifted;
  logic [ACC_W+1:0] trial;
  logic             q_bit;
  logic [ACC_W-1:0] rem_nx;
  logic [NUM_W-1:0] quo_nx;

  assign is_low   = bus.sample_valid && (bus.sample <= HYST_NEG);
  assign crossing = bus.sample_valid && armed_q && (bus.sample >= HYST_POS);
  // Period includes the crossing sample itself; saturate at the counter ceiling.
  assign per_len  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign sum_next = acc_q + ACC_W'(per_len);

  // Tracker next state: hysteresis arming, period counting and accumulation.
  always_comb begin
    trk_d      = trk_q;
    armed_d    = armed_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    no_pitch_d = no_pitch_q;
    ld_d       = 1'b0;
    ld_sum_d   = ld_sum_q;

    if (crossing)    armed_d = 1'b0;
    else if (is_low) armed_d = 1'b1;

    unique case (trk_q)
      T_SEEK: begin
        if (crossing) begin
          trk_d = T_TRACK;
          cnt_d = '0;
          acc_d = '0;
          idx_d = '0;
        end
      end
      T_TRACK: begin
        if (cnt_q > MAX_CNT) begin
          trk_d      = T_SEEK;
          no_pitch_d = 1'b1;
          cnt_d      = '0;
          acc_d      = '0;
          idx_d      = '0;
        end else if (crossing) begin
          cnt_d = '0;
          if (per_len < MIN_CNT) begin
            acc_d = '0;
            idx_d = '0;
          end else if (per_len > MAX_CNT) begin
            // Overlong period that ends on the very sample of the timeout.
            trk_d      = T_SEEK;
            no_pitch_d = 1'b1;
            acc_d      = '0;
            idx_d      = '0;
          end else if (idx_q == IDX_LAST) begin
            ld_d       = 1'b1;
            ld_sum_d   = sum_next;
            acc_d      = '0;
            idx_d      = '0;
            no_pitch_d = 1'b0;
          end else begin
            acc_d = sum_next;
            idx_d = idx_q + 1'b1;
          end
        end else if (bus.sample_valid) begin
          cnt_d = per_len;
        end
      end
      default: trk_d = T_SEEK;
    endcase
  end

  // Tracker registers; enable low forces the idle state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_q      <= T_SEEK;
      armed_q    <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      no_pitch_q <= 1'b1;
      ld_q       <= 1'b0;
    end else if (!bus.enable) begin
      trk_q      <= T_SEEK;
      armed_q    <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      no_pitch_q <= 1'b1;
      ld_q       <= 1'b0;
    end else begin
      trk_q      <= trk_d;
      armed_q    <= armed_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      no_pitch_q <= no_pitch_d;
      ld_q       <= ld_d;
    end
  end

  // One restoring-division step: shift in the next numerator bit, try the subtract.
  assign shifted = {rem_q, quo_q[NUM_W-1]};
  assign trial   = {1'b0, shifted} - {2'b00, dvs_q};
  assign q_bit   = ~trial[ACC_W+1];
  assign rem_nx  = q_bit ? trial[ACC_W-1:0] : shifted[ACC_W-1:0];
  assign quo_nx  = {quo_q[NUM_W-2:0], q_bit};

  // Divider next state; a sum arriving while busy is simply dropped.
  always_comb begin
    div_d     = div_q;
    it_d      = it_q;
    freq_hz_d = freq_hz_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    unique case (div_q)
      DIV_IDLE: begin
        if (ld_q) begin
          div_d = DIV_RUN;
          it_d  = '0;
          rem_d = '0;
          quo_d = NUMER;
          dvs_d = ld_sum_q;
        end
      end
      DIV_RUN: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        it_d  = it_q + 1'b1;
        if (it_q == IT_LAST) begin
          div_d     = DIV_OUT;
          freq_hz_d = sat_quotient(quo_nx);
        end
      end
      DIV_OUT: div_d = DIV_IDLE;
      default: div_d = DIV_IDLE;
    endcase
  end

  // Divider control and output registers; enable low aborts but keeps freq_hz.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= DIV_IDLE;
      it_q      <= '0;
      freq_hz_q <= '0;
    end else if (!bus.enable) begin
      div_q     <= DIV_IDLE;
      it_q      <= '0;
    end else begin
      div_q     <= div_d;
      it_q      <= it_d;
      freq_hz_q <= freq_hz_d;
    end
  end

  // Datapath registers; only ever consumed under control of the FSMs above.
  always_ff @(posedge clk) begin
    ld_sum_q <= ld_sum_d;
    rem_q    <= rem_d;
    quo_q    <= quo_d;
    dvs_q    <= dvs_d;
  end

  assign bus.freq_hz    = freq_hz_q;
  assign bus.freq_valid = (div_q == DIV_OUT);
  assign bus.busy       = (div_q != DIV_IDLE);
  assign bus.no_pitch   = no_pitch_q;

endmodule
